// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared defaults and types for the frame-buffer write arbiter.
package fb_arb_pkg;
   localparam int FB_ADDR_W     = 19;
   localparam int FB_DATA_W     = 8;
   localparam int FB_FIFO_DEPTH = 4;

   typedef enum logic {PRI_CPU, PRI_ENG} pri_e;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] data;
   } fb_wr_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: small synchronous FIFO for processor writes; a push into a full
// FIFO with no same-cycle pop is dropped and latches a sticky overflow flag.
module fb_wr_fifo
   import fb_arb_pkg::*;
#(
   parameter type T     = fb_wr_t,
   parameter int  DEPTH = FB_FIFO_DEPTH
) (
   input  logic iCLK,
   input  logic iRST_n,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty,
   output logic overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
         if (push & ~do_push) overflow <= 1'b1;
      end

   // storage needs no reset: entries are only read behind a valid count
   always_ff @(posedge iCLK)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin share of the VGA frame-buffer write port between
// buffered processor stores and a valid/ready paint engine. Macro FB_ARB_BLANK_ONLY_EN
// restricts grants to blanking intervals.
module fb_write_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_full,
   output logic              cpu_overflow,
   input  logic              eng_req,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [DATA_W-1:0] eng_data,
   output logic              eng_gnt,
   input  logic              iBLANK_n,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t  cpu_wr, head;
   pri_e pri, pri_nxt;
   logic cpu_pend, cpu_gnt, fifo_empty, arb_en;

   assign cpu_wr   = {cpu_addr, cpu_data};
   assign cpu_pend = ~fifo_empty;

   fb_wr_fifo #(.T(wr_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .iCLK     (iCLK),
      .iRST_n   (iRST_n),
      .push     (cpu_we),
      .pop      (cpu_gnt),
      .din      (cpu_wr),
      .dout     (head),
      .full     (cpu_full),
      .empty    (fifo_empty),
      .overflow (cpu_overflow)
   );

`ifdef FB_ARB_BLANK_ONLY_EN
   assign arb_en = ~iBLANK_n;
`else
   // blanking has no effect here; the OR keeps the port referenced
   assign arb_en = iBLANK_n | 1'b1;
`endif

   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) pri <= PRI_CPU;
      else pri <= pri_nxt;

   always_comb begin
      cpu_gnt = arb_en & cpu_pend & (~eng_req | (pri == PRI_CPU));
      eng_gnt = arb_en & eng_req & (~cpu_pend | (pri == PRI_ENG));
      pri_nxt = cpu_gnt ? PRI_ENG : eng_gnt ? PRI_CPU : pri;
   end

   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         fb_we <= cpu_gnt | eng_gnt;
         if (cpu_gnt) begin
            fb_addr <= head.addr;
            fb_data <= head.data;
         end else if (eng_gnt) begin
            fb_addr <= eng_addr;
            fb_data <= eng_data;
         end
      end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based round-robin reference model.
module tb_fb_write_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int DEPTH = 4;
`ifdef FB_ARB_BLANK_ONLY_EN
   localparam bit GATE_EN = 1'b1;
`else
   localparam bit GATE_EN = 1'b0;
`endif

   logic          iCLK = 1'b0, iRST_n = 1'b0, cpu_we = 1'b0, eng_req = 1'b0, iBLANK_n = 1'b0;
   logic [AW-1:0] cpu_addr = '0, eng_addr = '0;
   logic [DW-1:0] cpu_data = '0, eng_data = '0;
   logic          cpu_full, cpu_overflow, eng_gnt, fb_we;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data;
   int            n_vec = 0, n_err = 0;

   always #5 iCLK = ~iCLK;

   fb_write_arbiter dut (
      .iCLK(iCLK), .iRST_n(iRST_n),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_full(cpu_full), .cpu_overflow(cpu_overflow),
      .eng_req(eng_req), .eng_addr(eng_addr), .eng_data(eng_data), .eng_gnt(eng_gnt),
      .iBLANK_n(iBLANK_n),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
   );

   // Reference: queued CPU writes; on contention the side not served most recently wins.
   logic [AW+DW-1:0] mq[$];
   bit               eng_last, m_ovf, m_we;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_data;

   function automatic void mdl_reset();
      mq.delete();
      eng_last = 1'b1;
      m_ovf = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
   endfunction

   function automatic bit mdl_open();
      return !GATE_EN || !iBLANK_n;
   endfunction

   function automatic bit mdl_cpu_wins();
      return mdl_open() && mq.size() > 0 && (!eng_req || eng_last);
   endfunction

   function automatic bit mdl_eng_wins();
      return mdl_open() && eng_req && (mq.size() == 0 || !eng_last);
   endfunction

   function automatic void mdl_clock();
      bit cw, ew;
      cw = mdl_cpu_wins();
      ew = mdl_eng_wins();
      m_we = cw || ew;
      if (cw) begin
         {m_addr, m_data} = mq.pop_front();
         eng_last = 1'b0;
      end else if (ew) begin
         m_addr = eng_addr;
         m_data = eng_data;
         eng_last = 1'b1;
      end
      if (cpu_we) begin
         if (mq.size() < DEPTH) mq.push_back({cpu_addr, cpu_data});
         else m_ovf = 1'b1;
      end
   endfunction

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic apply_reset();
      cpu_we = 0;
      eng_req = 0;
      iBLANK_n = 0;
      iRST_n = 0;
      repeat (2) tick();
      iRST_n = 1;
      mdl_reset();
   endtask

   task automatic test_reset();
      iRST_n = 0;
      #3;
      n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", fb_we); end
      n_vec++; if (fb_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h exp 0", fb_addr); end
      n_vec++; if (fb_data !== '0) begin n_err++; $display("FAIL reset_data: got %h exp 0", fb_data); end
      n_vec++; if (cpu_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", cpu_full); end
      n_vec++; if (cpu_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b exp 0", cpu_overflow); end
      tick();
      iRST_n = 1;
      mdl_reset();
   endtask

   task automatic test_cpu_single();
      cpu_we = 1; cpu_addr = 19'h00010; cpu_data = 8'h3C;
      tick();
      cpu_we = 0;
      n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL cpu_lat1_we: got %b exp 0", fb_we); end
      tick();
      n_vec++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL cpu_lat2_we: got %b exp 1", fb_we); end
      n_vec++; if (fb_addr !== 19'h00010) begin n_err++; $display("FAIL cpu_addr: got %h exp 00010", fb_addr); end
      n_vec++; if (fb_data !== 8'h3C) begin n_err++; $display("FAIL cpu_data: got %h exp 3c", fb_data); end
      n_vec++; if (cpu_full !== 1'b0) begin n_err++; $display("FAIL cpu_full: got %b exp 0", cpu_full); end
      tick();
      n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL cpu_pulse: got %b exp 0", fb_we); end
   endtask

   task automatic test_eng_single();
      eng_req = 1; eng_addr = 19'h12345; eng_data = 8'h7F;
      #1;
      n_vec++; if (eng_gnt !== 1'b1) begin n_err++; $display("FAIL eng_gnt: got %b exp 1", eng_gnt); end
      tick();
      eng_req = 0;
      n_vec++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL eng_we: got %b exp 1", fb_we); end
      n_vec++; if (fb_addr !== 19'h12345) begin n_err++; $display("FAIL eng_addr: got %h exp 12345", fb_addr); end
      n_vec++; if (fb_data !== 8'h7F) begin n_err++; $display("FAIL eng_data: got %h exp 7f", fb_data); end
      tick();
   endtask

   task automatic test_interleave();
      logic [AW+DW-1:0] ew [4];
      logic [AW+DW-1:0] exp_seq [6];
      logic [AW+DW-1:0] got[$];
      int k = 0, first = -1, last = -1;
      bit g;
      ew[0] = {19'h00E01, 8'hE1}; ew[1] = {19'h00E02, 8'hE2};
      ew[2] = {19'h00E03, 8'hE3}; ew[3] = {19'h00E04, 8'hE4};
      exp_seq[0] = {19'h00A00, 8'hAA}; exp_seq[1] = ew[0];
      exp_seq[2] = {19'h00B00, 8'hBB}; exp_seq[3] = ew[1];
      exp_seq[4] = ew[2]; exp_seq[5] = ew[3];
      for (int c = 0; c < 10; c++) begin
         cpu_we = c < 2;
         {cpu_addr, cpu_data} = c == 0 ? {19'h00A00, 8'hAA} : {19'h00B00, 8'hBB};
         eng_req = c >= 1 && k < 4;
         {eng_addr, eng_data} = ew[k < 4 ? k : 3];
         #1;
         g = eng_gnt && eng_req;
         tick();
         if (g) k++;
         if (fb_we) begin
            got.push_back({fb_addr, fb_data});
            if (first < 0) first = c;
            last = c;
         end
      end
      cpu_we = 0; eng_req = 0;
      n_vec++; if (k !== 4) begin n_err++; $display("FAIL ilv_eng_grants: got %0d exp 4", k); end
      n_vec++; if (got.size() !== 6 || last - first !== 5) begin
         n_err++; $display("FAIL ilv_burst: got %0d writes over %0d cycles exp 6 over 6", got.size(), last - first + 1);
      end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         n_vec++; if (got[i] !== exp_seq[i]) begin n_err++; $display("FAIL ilv_seq[%0d]: got %h exp %h", i, got[i], exp_seq[i]); end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         cpu_we = 1; cpu_addr = AW'(19'h00C00 + c); cpu_data = DW'(8'hC0 + c);
         eng_req = 1; eng_addr = AW'(19'h00D00 + c); eng_data = DW'(8'hD0 + c);
         mdl_clock();
         tick();
      end
      cpu_we = 0; eng_req = 0;
      n_vec++; if (fb_we !== 1'b1 || mq.size() !== 3) begin
         n_err++; $display("FAIL mrst_pre: got we=%b exp 1 (model depth %0d exp 3)", fb_we, mq.size());
      end
      iRST_n = 0;
      #1;
      n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL mrst_we: got %b exp 0", fb_we); end
      n_vec++; if (fb_addr !== '0) begin n_err++; $display("FAIL mrst_addr: got %h exp 0", fb_addr); end
      tick(); tick();
      iRST_n = 1;
      mdl_reset();
      for (int c = 0; c < 6; c++) begin
         tick();
         n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL mrst_stale[%0d]: got we=%b exp 0", c, fb_we); end
      end
   endtask

   task automatic test_overflow();
      bit g = 1'b1;
      apply_reset();
      for (int c = 0; c < 24; c++) begin
         cpu_we = c < 12;
         cpu_addr = AW'($urandom); cpu_data = DW'(c + 1);
         if (g) begin eng_addr = AW'($urandom); eng_data = DW'($urandom); end
         eng_req = c < 12;
         #1;
         g = eng_gnt;
         n_vec++; if (eng_gnt !== mdl_eng_wins()) begin n_err++; $display("FAIL ovf_gnt[%0d]: got %b exp %b", c, eng_gnt, mdl_eng_wins()); end
         n_vec++; if (cpu_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL ovf_full[%0d]: got %b exp %b", c, cpu_full, mq.size() == DEPTH); end
         mdl_clock();
         tick();
         n_vec++; if (fb_we !== m_we || fb_addr !== m_addr || fb_data !== m_data) begin
            n_err++; $display("FAIL ovf_fb[%0d]: got %b %h %h exp %b %h %h", c, fb_we, fb_addr, fb_data, m_we, m_addr, m_data);
         end
         n_vec++; if (cpu_overflow !== m_ovf) begin n_err++; $display("FAIL ovf_flag[%0d]: got %b exp %b", c, cpu_overflow, m_ovf); end
      end
      cpu_we = 0; eng_req = 0;
      n_vec++; if (cpu_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b exp 1", cpu_overflow); end
   endtask

   task automatic test_random();
      bit g = 1'b0;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         cpu_we = $urandom_range(0, 9) < 4;
         cpu_addr = AW'($urandom); cpu_data = DW'($urandom);
         if (!eng_req || g) begin
            eng_req = $urandom_range(0, 9) < 6;
            eng_addr = AW'($urandom); eng_data = DW'($urandom);
         end
         iBLANK_n = $urandom_range(0, 9) < 3;
         #1;
         g = eng_gnt;
         n_vec++; if (eng_gnt !== mdl_eng_wins()) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b exp %b", c, eng_gnt, mdl_eng_wins()); end
         n_vec++; if (cpu_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d]: got %b exp %b", c, cpu_full, mq.size() == DEPTH); end
         mdl_clock();
         tick();
         n_vec++; if (fb_we !== m_we || fb_addr !== m_addr || fb_data !== m_data) begin
            n_err++; $display("FAIL rnd_fb[%0d]: got %b %h %h exp %b %h %h", c, fb_we, fb_addr, fb_data, m_we, m_addr, m_data);
         end
         n_vec++; if (cpu_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b exp %b", c, cpu_overflow, m_ovf); end
      end
      cpu_we = 0; eng_req = 0; iBLANK_n = 0;
   endtask

   task automatic test_blank();
      apply_reset();
      eng_req = 1; eng_addr = 19'h0BEEF; eng_data = 8'h5A;
`ifdef FB_ARB_BLANK_ONLY_EN
      iBLANK_n = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_vec++; if (eng_gnt !== 1'b0) begin n_err++; $display("FAIL blank_gnt[%0d]: got %b exp 0", c, eng_gnt); end
         tick();
         n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL blank_we[%0d]: got %b exp 0", c, fb_we); end
      end
      iBLANK_n = 0;
`else
      iBLANK_n = 1;
`endif
      #1;
      n_vec++; if (eng_gnt !== 1'b1) begin n_err++; $display("FAIL blank_open_gnt: got %b exp 1", eng_gnt); end
      tick();
      eng_req = 0; iBLANK_n = 0;
      n_vec++; if (fb_we !== 1'b1 || fb_addr !== 19'h0BEEF) begin
         n_err++; $display("FAIL blank_open_fb: got %b %h exp 1 0beef", fb_we, fb_addr);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_single();
      test_eng_single();
      test_interleave();
      test_mid_reset();
      test_overflow();
      test_random();
      test_blank();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
